seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit, active-low 7-segment scan driver.
// A new value is loaded into a shadow register and only becomes visible at a frame boundary, so a frame never mixes two values.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic        pending,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] disp_val_q, disp_val_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        tick;
    logic        boundary;
    logic [3:0]  nibble;
    logic [3:0]  lead_zero;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Digit k is a leading zero when it and every digit to its left are zero; digit 0 always shows.
    assign lead_zero[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lead_zero
            assign lead_zero[gi] = ~|disp_val_q[15:4*gi];
        end
    endgenerate

    always_comb begin
        tick     = (presc_q == DIV_LAST);
        boundary = tick && (idx_q == 2'd3);
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        idx_d    = tick ? idx_q + 2'd1 : idx_q;

        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_en : pend_dp_q;

        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pending_d  = pending_q;
        if (boundary) begin
            // A load landing on the boundary bypasses the shadow and wins over an older pending value.
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_en;
            end else if (pending_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end

        nibble = disp_val_q[{idx_q, 2'b00} +: 4];
        an_d   = ~(4'b0001 << idx_q);
        seg_d  = (blank_lz && lead_zero[idx_q]) ? 7'h7F : hex_to_seg(nibble);
        dp_d   = ~disp_dp_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= 16'd0;
            idx_q      <= 2'd0;
            disp_val_q <= 16'd0;
            disp_dp_q  <= 4'd0;
            pend_val_q <= 16'd0;
            pend_dp_q  <= 4'd0;
            pending_q  <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign pending = pending_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4 (one digit per 4 clocks, one frame per 16 clocks).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp_en    (dp_en),
        .blank_lz (blank_lz),
        .pending  (pending),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpe;
        logic        blz;
        logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
        logic [3:0]  dps;   // expected dp output per digit
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic wait_pending_low(input string name);
        int n;
        n = 0;
        while (pending !== 1'b0 && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) chk({name, "_pending_timeout"}, 32'(pending), 32'd0);
    endtask

    task automatic wait_an(input string name, input logic [3:0] pat);
        int n;
        n = 0;
        while (an !== pat && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk({name, "_an_timeout"}, 32'(an), 32'(pat));
    endtask

    // Leaves the bench at the negedge just before a frame-boundary clock edge.
    task automatic sync_to_boundary();
        logic [3:0] prev;
        bit found;
        found = 0;
        prev = an;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (prev !== 4'b0111 && an === 4'b0111) found = 1;
            prev = an;
        end
        if (!found) chk("sync_timeout", 32'(an), 32'h7);
        step();
        step();
    endtask

    // Checks the 16 cycles following reset release with disp_val = 0.
    task automatic release_seq(input string tag);
        logic [3:0] exp_an;
        for (int c = 1; c <= 16; c++) begin
            step();
            case ((c - 1) / 4)
                0: exp_an = 4'b1110;
                1: exp_an = 4'b1101;
                2: exp_an = 4'b1011;
                default: exp_an = 4'b0111;
            endcase
            chk($sformatf("%s_c%0d_an", tag, c), 32'(an), 32'(exp_an));
            chk($sformatf("%s_c%0d_seg", tag, c), 32'(seg), 32'h40);
            chk($sformatf("%s_c%0d_dp", tag, c), 32'(dp), 32'h1);
        end
        chk({tag, "_pending"}, 32'(pending), 32'd0);
    endtask

    initial begin
        logic [3:0]  an_pat;
        logic [6:0]  exp_seg [4];
        logic [3:0]  exp_dp;

        vecs[0] = '{16'h12AF, 4'b0010, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1101};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
        vecs[2] = '{16'h0005, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1111};
        vecs[3] = '{16'h0300, 4'b1001, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b0110};
        vecs[4] = '{16'h89CD, 4'b1111, 1'b1, {7'h00, 7'h10, 7'h46, 7'h21}, 4'b0000};
        vecs[5] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};
        vecs[6] = '{16'h4567, 4'b0000, 1'b0, {7'h19, 7'h12, 7'h02, 7'h78}, 4'b1111};
        vecs[7] = '{16'hB3E0, 4'b0000, 1'b1, {7'h03, 7'h30, 7'h06, 7'h40}, 4'b1111};

        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_en    = 4'h0;
        blank_lz = 1'b0;

        // Reset state
        @(negedge clk);
        step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_pending", 32'(pending), 32'd0);

        // Reset release scan sequence
        rst_n = 1'b1;
        release_seq("rel");

        // Mid-frame load: shown only from the next frame boundary (edge 32)
        step();
        load  = 1'b1;
        value = 16'h12AF;
        dp_en = 4'b0010;
        step();
        load = 1'b0;
        chk("mid_pending_set", 32'(pending), 32'd1);
        for (int i = 0; i < 13; i++) step();
        chk("mid_pending_hold", 32'(pending), 32'd1);
        chk("mid_old_seg", 32'(seg), 32'h40);
        step();
        chk("mid_pending_clr", 32'(pending), 32'd0);
        exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        exp_dp  = 4'b1101;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                an_pat = ~(4'b0001 << d);
                chk($sformatf("mid_d%0d_c%0d_an", d, c), 32'(an), 32'(an_pat));
                chk($sformatf("mid_d%0d_c%0d_seg", d, c), 32'(seg), 32'(exp_seg[d]));
                chk($sformatf("mid_d%0d_c%0d_dp", d, c), 32'(dp), 32'(exp_dp[d]));
            end
        end

        // Table of decode / blanking / dp vectors
        for (int v = 0; v < 8; v++) begin
            step();
            load     = 1'b1;
            value    = vecs[v].val;
            dp_en    = vecs[v].dpe;
            blank_lz = vecs[v].blz;
            step();
            load = 1'b0;
            wait_pending_low($sformatf("vec%0d", v));
            for (int k = 0; k < 4; k++) begin
                an_pat = ~(4'b0001 << k);
                wait_an($sformatf("vec%0d_d%0d", v, k), an_pat);
                chk($sformatf("vec%0d_d%0d_seg", v, k), 32'(seg), 32'(vecs[v].segs[7*k +: 7]));
                chk($sformatf("vec%0d_d%0d_dp", v, k), 32'(dp), 32'(vecs[v].dps[k]));
            end
        end
        blank_lz = 1'b0;

        // Load exactly on a frame boundary bypasses the shadow
        sync_to_boundary();
        load  = 1'b1;
        value = 16'h3333;
        dp_en = 4'b0000;
        step();
        load = 1'b0;
        chk("bnd_pending", 32'(pending), 32'd0);
        chk("bnd_last_an", 32'(an), 32'h7);
        step();
        chk("bnd_next_an", 32'(an), 32'hE);
        chk("bnd_next_seg", 32'(seg), 32'h30);
        chk("bnd_pending_after", 32'(pending), 32'd0);

        // Two loads in one frame: only the last one is displayed
        sync_to_boundary();
        step();
        load  = 1'b1;
        value = 16'h1111;
        step();
        load = 1'b0;
        chk("dbl_pending1", 32'(pending), 32'd1);
        for (int i = 0; i < 3; i++) step();
        load  = 1'b1;
        value = 16'h2222;
        step();
        load = 1'b0;
        chk("dbl_pending2", 32'(pending), 32'd1);
        chk("dbl_old_seg", 32'(seg), 32'h30);
        wait_pending_low("dbl");
        for (int k = 0; k < 4; k++) begin
            an_pat = ~(4'b0001 << k);
            wait_an($sformatf("dbl_d%0d", k), an_pat);
            chk($sformatf("dbl_d%0d_seg", k), 32'(seg), 32'h24);
        end

        // Reset while a value is pending discards it
        sync_to_boundary();
        step();
        step();
        load  = 1'b1;
        value = 16'h4444;
        step();
        load = 1'b0;
        chk("rp_pending", 32'(pending), 32'd1);
        rst_n = 1'b0;
        load  = 1'b1;
        value = 16'h5555;
        step();
        load = 1'b0;
        chk("rp_rst_pending", 32'(pending), 32'd0);
        chk("rp_rst_an", 32'(an), 32'hF);
        chk("rp_rst_seg", 32'(seg), 32'h7F);
        chk("rp_rst_dp", 32'(dp), 32'h1);
        rst_n = 1'b1;
        release_seq("rp");
        for (int c = 0; c < 16; c++) begin
            step();
            chk($sformatf("rp_post_c%0d_seg", c), 32'(seg), 32'h40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
